l2_tcdm_interleaved_mem: RTL and testbench
==========================================

Name: l2_tcdm_interleaved_mem

Overview:
Multi-port, word-interleaved L2 memory slave for the TCDM/lint bus. It lets the JTAG lint master and further bus masters reach a shared L2 concurrently through per-bank round-robin arbitration. It replaces the single-bank, single-master L2 hookup used in the JTAG bring-up top level. Each port responds with a fixed one-cycle latency and flags out-of-range accesses.

Parameters:
N_MASTERS, 2, number of TCDM master ports (port 0 is the JTAG lint master); 1..8
NB_BANKS, 4, number of word-interleaved banks; power of 2, 1..16
BANK_WORDS, 8192, 32-bit words per bank; power of 2
BASE_ADDR, 32'h1C00_0000, byte address of word 0; aligned to the total memory size
ERR_DATA, 32'hBADA_CCE5, read data returned on an out-of-range access

Ports:
clk_i  in  1  clock; all logic is rising-edge
rst_i  in  1  synchronous active-high reset
req_i  in  N_MASTERS  per-port request
add_i  in  32*N_MASTERS  per-port byte address (port p = bits [32p+31:32p])
wen_i  in  N_MASTERS  1 = read, 0 = write (TCDM convention)
wdata_i  in  32*N_MASTERS  write data
be_i  in  4*N_MASTERS  byte enables; be[k] covers bits [8k+7:8k]
gnt_o  out  N_MASTERS  grant (combinational from req)
r_valid_o  out  N_MASTERS  response valid
r_rdata_o  out  32*N_MASTERS  read data
r_opc_o  out  N_MASTERS  1 = error response (out of range)

Behaviour:
- Address decode:
  - off = add - BASE_ADDR
  - word = off[31:2]; add[1:0] is ignored
  - bank = word mod NB_BANKS (low bits)
  - row = word / NB_BANKS
  - in_range when add >= BASE_ADDR and off < NB_BANKS*BANK_WORDS*4
- Handshake:
  - A transfer occurs on a cycle where req_i[p] and gnt_o[p] are both 1.
  - Masters hold req/add/wen/wdata/be stable until granted. A request withdrawn before grant is legal and causes no access.
  - gnt_o[p] is 0 whenever req_i[p] is 0.
- Out-of-range request: granted unconditionally in the same cycle, with no bank access and no arbitration.
- Arbitration, per bank:
  - Among in-range requesters targeting that bank, exactly one is granted per cycle.
  - Round-robin: a per-bank pointer rr[b] marks the highest-priority port. Priority is rr[b], rr[b]+1, ... mod N_MASTERS.
  - After a grant to port p on bank b, rr[b] <= (p+1) mod N_MASTERS. Idle banks keep their pointer.
  - Ports targeting different banks are granted in the same cycle with no interaction.
- Memory access: performed in the granted cycle.
  - Write: each byte with be=1 is updated; other bytes are unchanged. be=4'b0000 makes no change but still returns a response.
  - Read: returns the row contents as of the start of the cycle.
- Response:
  - r_valid_o[p] is 1 exactly one cycle after the grant.
  - Read, in range: r_rdata = stored word, r_opc = 0.
  - Write, in range: r_rdata = 0, r_opc = 0.
  - Out of range: r_opc = 1; r_rdata = ERR_DATA for a read and 0 for a write; memory is untouched.
  - r_rdata_o and r_opc_o are 0 in any cycle where r_valid_o = 0.
  - Back-to-back grants give back-to-back responses, one per cycle per port.
- Simultaneous events:
  - A write and a read to the same row in the same cycle cannot occur, because they are the same bank and only one is granted.
  - A write at cycle n followed by a read of the same address at cycle n+1 returns the new data.
- Reset (rst_i = 1, sampled at the rising edge):
  - Next cycle: r_valid_o = 0, r_rdata_o = 0, r_opc_o = 0, all rr[b] = 0.
  - While rst_i = 1: gnt_o = 0 and no write takes effect.
  - A response pending at reset is dropped.
  - Memory contents are not cleared.
- No X may propagate from unread or uninitialised rows to r_opc_o or r_valid_o.

Test Plan:
- Single port: port 0 writes 32'hDEADBEEF to BASE_ADDR+0x10 (be=4'hF), then reads it -> gnt in the request cycle, r_valid one cycle later for each access, read r_rdata=32'hDEADBEEF, r_opc=0.
- Byte enables: write 32'h11223344 (be=4'hF), then write 32'hAABBCCDD with be=4'b0101, then read -> 32'h11BB33DD.
- Bank conflict, N_MASTERS=2, NB_BANKS=4: both ports read BASE_ADDR+0x0 and BASE_ADDR+0x10 (both bank 0), held every cycle -> grants alternate p0, p1, p0, ... starting with p0 after reset; no cycle grants both.
- No conflict: p0 accesses BASE_ADDR+0x0 (bank 0) and p1 accesses BASE_ADDR+0x4 (bank 1) -> both granted in the same cycle, both r_valid the next cycle.
- Out of range: read BASE_ADDR+NB_BANKS*BANK_WORDS*4 -> gnt in the same cycle, r_valid next cycle with r_opc=1 and r_rdata=32'hBADACCE5. Repeat as a write to BASE_ADDR-4 -> r_opc=1, r_rdata=0, and memory unchanged on readback.
- Reset mid-operation: grant a read, assert rst_i on the next edge -> r_valid_o=0 and gnt_o=0 while in reset; after release the data written before reset still reads back intact and the round-robin restarts at p0.

Source files
------------

// File: rtl/l2_tcdm_interleaved_mem.sv
// Word-interleaved multi-port L2 slave for the TCDM bus: per-bank round-robin
// arbitration, one-cycle response latency, error response for out-of-range accesses.
module l2_tcdm_interleaved_mem #(
  parameter int unsigned N_MASTERS  = 2,
  parameter int unsigned NB_BANKS   = 4,
  parameter int unsigned BANK_WORDS = 8192,
  parameter logic [31:0] BASE_ADDR  = 32'h1C00_0000,
  parameter logic [31:0] ERR_DATA   = 32'hBADA_CCE5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_MASTERS-1:0]      req_i,
  input  logic [32*N_MASTERS-1:0]   add_i,
  input  logic [N_MASTERS-1:0]      wen_i,
  input  logic [32*N_MASTERS-1:0]   wdata_i,
  input  logic [4*N_MASTERS-1:0]    be_i,
  output logic [N_MASTERS-1:0]      gnt_o,
  output logic [N_MASTERS-1:0]      r_valid_o,
  output logic [32*N_MASTERS-1:0]   r_rdata_o,
  output logic [N_MASTERS-1:0]      r_opc_o
);

  localparam int unsigned MEM_WORDS = NB_BANKS * BANK_WORDS;
  localparam int unsigned IDX_BITS  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned PORT_BITS = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

  // Flat word array: the low word-index bits select the bank, so this is the interleaved layout.
  logic [31:0]                  r_mem [MEM_WORDS];
  logic [PORT_BITS-1:0]         r_rr [NB_BANKS];
  logic [N_MASTERS-1:0]         r_valid;
  logic [N_MASTERS-1:0]         r_opc;
  logic [N_MASTERS-1:0][31:0]   r_rdata;

  logic [N_MASTERS-1:0][31:0]   w_off;
  logic [N_MASTERS-1:0][29:0]   w_word;
  logic [N_MASTERS-1:0][IDX_BITS-1:0] w_idx;
  logic [N_MASTERS-1:0]         w_in_range;
  logic [N_MASTERS-1:0]         w_arb_req;
  logic [N_MASTERS-1:0]         w_gnt;
  int unsigned                  w_bank [N_MASTERS];
  logic [NB_BANKS-1:0]          w_bank_hit;
  logic [PORT_BITS-1:0]         w_bank_port [NB_BANKS];
  logic [PORT_BITS-1:0]         w_cand;

  // Address decode per port.
  always_comb begin
    for (int unsigned p = 0; p < N_MASTERS; p++) begin
      w_off[p]      = add_i[32*p +: 32] - BASE_ADDR;
      w_word[p]     = 30'(w_off[p] >> 2);
      w_idx[p]      = IDX_BITS'(w_word[p]);
      w_bank[p]     = 32'(w_word[p]) % NB_BANKS;
      w_in_range[p] = (add_i[32*p +: 32] >= BASE_ADDR) && ({1'b0, w_off[p]} < MEM_BYTES);
      w_arb_req[p]  = !rst_i && req_i[p] && w_in_range[p];
    end
  end

  // Per-bank round-robin; out-of-range requests bypass arbitration.
  always_comb begin
    w_bank_hit = '0;
    w_cand     = '0;
    w_gnt      = req_i & ~w_in_range & {N_MASTERS{!rst_i}};
    for (int unsigned b = 0; b < NB_BANKS; b++) begin
      w_bank_port[b] = '0;
      for (int unsigned k = 0; k < N_MASTERS; k++) begin
        w_cand = PORT_BITS'((32'(r_rr[b]) + k) % N_MASTERS);
        if (!w_bank_hit[b] && w_arb_req[w_cand] && (w_bank[w_cand] == b)) begin
          w_bank_hit[b]  = 1'b1;
          w_bank_port[b] = w_cand;
          w_gnt[w_cand]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned b = 0; b < NB_BANKS; b++) r_rr[b] <= '0;
    end else begin
      for (int unsigned b = 0; b < NB_BANKS; b++) begin
        if (w_bank_hit[b]) r_rr[b] <= PORT_BITS'((32'(w_bank_port[b]) + 1) % N_MASTERS);
      end
    end
  end

  // Byte-masked writes; no reset so contents survive rst_i.
  always_ff @(posedge clk_i) begin
    for (int unsigned p = 0; p < N_MASTERS; p++) begin
      if (w_gnt[p] && w_in_range[p] && !wen_i[p]) begin
        for (int unsigned k = 0; k < 4; k++) begin
          if (be_i[4*p+k]) r_mem[w_idx[p]][8*k +: 8] <= wdata_i[32*p + 8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= '0;
      r_opc   <= '0;
      r_rdata <= '0;
    end else begin
      for (int unsigned p = 0; p < N_MASTERS; p++) begin
        r_valid[p] <= w_gnt[p];
        r_opc[p]   <= w_gnt[p] && !w_in_range[p];
        if (!w_gnt[p])          r_rdata[p] <= '0;
        else if (!w_in_range[p]) r_rdata[p] <= wen_i[p] ? ERR_DATA : 32'h0;
        else if (wen_i[p])       r_rdata[p] <= r_mem[w_idx[p]];
        else                     r_rdata[p] <= '0;
      end
    end
  end

  assign gnt_o     = w_gnt;
  assign r_valid_o = r_valid;
  assign r_opc_o   = r_opc;
  assign r_rdata_o = r_rdata;

endmodule

// File: tb/tb_l2_tcdm_interleaved_mem.sv
// Directed bench for l2_tcdm_interleaved_mem: vector table plus reset and
// bank-conflict sequences.
module tb_l2_tcdm_interleaved_mem;

  localparam logic [31:0] B = 32'h1C00_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, wen, gnt, rvalid, opc;
  logic [63:0] add, wdata, rdata;
  logic [7:0]  be;

  int checks   = 0;
  int failures = 0;

  l2_tcdm_interleaved_mem dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt), .r_valid_o(rvalid),
    .r_rdata_o(rdata), .r_opc_o(opc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req, wen;
    logic [31:0] a0, a1, d0, d1;
    logic [3:0]  be0, be1;
    logic [1:0]  gnt, opc;
    logic [31:0] r0, r1;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic [1:0] rq, input logic [1:0] wn,
                              input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] be0,
                              input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] be1,
                              input logic [1:0] g, input logic [1:0] o,
                              input logic [31:0] r0, input logic [31:0] r1);
    vec_t v;
    v.req = rq; v.wen = wn; v.a0 = a0; v.d0 = d0; v.be0 = be0;
    v.a1 = a1; v.d1 = d1; v.be1 = be1; v.gnt = g; v.opc = o; v.r0 = r0; v.r1 = r1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req = v.req; wen = v.wen;
    add = {v.a1, v.a0}; wdata = {v.d1, v.d0}; be = {v.be1, v.be0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ports: req wen | a0 d0 be0 | a1 d1 be1 | gnt opc r0 r1
    vecs[0]  = mk(2'b01, 2'b00, B+32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 32'h0, 4'h0, 2'b01, 2'b00, 32'h0, 32'h0);
    vecs[1]  = mk(2'b01, 2'b01, B+32'h10, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 2'b01, 2'b00, 32'hDEADBEEF, 32'h0);
    vecs[2]  = mk(2'b01, 2'b00, B+32'h20, 32'h11223344, 4'hF, 32'h0, 32'h0, 4'h0, 2'b01, 2'b00, 32'h0, 32'h0);
    vecs[3]  = mk(2'b01, 2'b00, B+32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 32'h0, 4'h0, 2'b01, 2'b00, 32'h0, 32'h0);
    vecs[4]  = mk(2'b01, 2'b01, B+32'h20, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 2'b01, 2'b00, 32'h11BB33DD, 32'h0);
    vecs[5]  = mk(2'b11, 2'b00, B+32'h0, 32'hCAFE0001, 4'hF, B+32'h4, 32'h12345678, 4'hF, 2'b11, 2'b00, 32'h0, 32'h0);
    vecs[6]  = mk(2'b11, 2'b11, B+32'h4, 32'h0, 4'h0, B+32'h0, 32'h0, 4'h0, 2'b11, 2'b00, 32'h12345678, 32'hCAFE0001);
    vecs[7]  = mk(2'b10, 2'b00, 32'h0, 32'h0, 4'h0, B+32'h1FFFC, 32'h0F0F0F0F, 4'hF, 2'b10, 2'b00, 32'h0, 32'h0);
    vecs[8]  = mk(2'b01, 2'b01, B+32'h20000, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 2'b01, 2'b01, 32'hBADACCE5, 32'h0);
    vecs[9]  = mk(2'b11, 2'b10, B-32'h4, 32'hFFFFFFFF, 4'hF, B+32'h10, 32'h0, 4'h0, 2'b11, 2'b01, 32'h0, 32'hDEADBEEF);
    vecs[10] = mk(2'b01, 2'b01, B+32'h1FFFC, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 2'b01, 2'b00, 32'h0F0F0F0F, 32'h0);
    vecs[11] = mk(2'b00, 2'b11, B+32'h10, 32'h0, 4'h0, B+32'h10, 32'h0, 4'h0, 2'b00, 2'b00, 32'h0, 32'h0);
    vecs[12] = mk(2'b10, 2'b00, 32'h0, 32'h0, 4'h0, B+32'h10, 32'h0, 4'h0, 2'b10, 2'b00, 32'h0, 32'h0);
    vecs[13] = mk(2'b10, 2'b10, 32'h0, 32'h0, 4'h0, B+32'h10, 32'h0, 4'h0, 2'b10, 2'b00, 32'h0, 32'hDEADBEEF);

    rst = 1'b1; req = '0; wen = '1; add = '0; wdata = '0; be = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 64'(rvalid), 64'h0);
    chk("reset_opc", 64'(opc), 64'h0);
    chk("reset_rdata", rdata, 64'h0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_gnt", i), 64'(gnt), 64'(vecs[i].gnt));
      step();
      chk($sformatf("v%0d_valid", i), 64'(rvalid), 64'(vecs[i].gnt));
      chk($sformatf("v%0d_opc", i), 64'(opc), 64'(vecs[i].opc));
      chk($sformatf("v%0d_rdata", i), rdata, {vecs[i].r1, vecs[i].r0});
    end

    // Reset mid-operation: p0 read granted (moves rr[0] to 1), then reset with a p1 write held.
    req = 2'b01; wen = 2'b01; add = {32'h0, B+32'h10}; wdata = '0; be = '0;
    #1;
    chk("pre_reset_gnt", 64'(gnt), 64'h1);
    step();
    rst = 1'b1;
    req = 2'b11; wen = 2'b01; add = {B+32'h0, B+32'h10}; wdata = 64'h0; be = 8'hF0;
    #1;
    chk("in_reset_gnt", 64'(gnt), 64'h0);
    for (int c = 0; c < 2; c++) begin
      step();
      chk($sformatf("in_reset_valid%0d", c), 64'(rvalid), 64'h0);
      chk($sformatf("in_reset_gnt%0d", c), 64'(gnt), 64'h0);
      chk($sformatf("in_reset_rdata%0d", c), rdata, 64'h0);
    end
    rst = 1'b0;

    // Bank-0 conflict held: grants alternate p0, p1, ... starting at p0 after reset.
    req = 2'b11; wen = 2'b11; add = {B+32'h10, B+32'h0}; wdata = '0; be = '0;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("conf%0d_gnt", c), 64'(gnt), (c % 2 == 0) ? 64'h1 : 64'h2);
      step();
      chk($sformatf("conf%0d_valid", c), 64'(rvalid), (c % 2 == 0) ? 64'h1 : 64'h2);
      chk($sformatf("conf%0d_rdata", c), rdata,
          (c % 2 == 0) ? 64'h0000_0000_CAFE_0001 : 64'hDEAD_BEEF_0000_0000);
    end
    req = '0;
    #1;
    chk("idle_gnt", 64'(gnt), 64'h0);
    step();
    chk("idle_valid", 64'(rvalid), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
